// File: rtl/attn_value_accumulator.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : attn_value_accumulator
// Description : Attention value stage. Accepts one packed softmax weight row
//               p, then multiply-accumulates DATA_LENGTH streamed rows of V
//               into o[j] = sum_i p[i]*V[i][j], and presents the quantized
//               output row over a valid/ready handshake.
//               Optional macro ATTN_VALUE_SATURATE_EN clamps each output
//               element to the signed DATA_WIDTH range instead of wrapping.
// Revision    : 1.0 - initial release
// ============================================================================
module attn_value_accumulator #(
    parameter int WEIGHT_WIDTH = 16,
    parameter int DATA_WIDTH   = 16,
    parameter int DATA_LENGTH  = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [WEIGHT_WIDTH*DATA_LENGTH-1:0] w_in,
    input  logic                              w_valid,
    output logic                              w_ready,
    input  logic [DATA_WIDTH*DATA_LENGTH-1:0] v_in,
    input  logic                              v_valid,
    output logic                              v_ready,
    output logic [DATA_WIDTH*DATA_LENGTH-1:0] out,
    output logic                              out_valid,
    input  logic                              out_ready
);

    // Accumulator is wide enough for DATA_LENGTH full-scale signed products.
    localparam int ACC_WIDTH  = WEIGHT_WIDTH + DATA_WIDTH + 1 + $clog2(DATA_LENGTH);
    localparam int PROD_WIDTH = WEIGHT_WIDTH + 1 + DATA_WIDTH;
    // Weights carry WEIGHT_WIDTH/2 fractional bits; V already matches the output format.
    localparam int FRAC_BITS  = WEIGHT_WIDTH / 2;
    localparam int CNT_WIDTH  = (DATA_LENGTH > 1) ? $clog2(DATA_LENGTH) : 1;
    localparam logic [CNT_WIDTH-1:0] LAST_IDX = CNT_WIDTH'(DATA_LENGTH - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACCUM = 2'd1;
    localparam logic [1:0] S_OUT   = 2'd2;

    logic [1:0]                   state_q;
    logic [1:0]                   state_d;
    logic [CNT_WIDTH-1:0]         count_q;
    logic [CNT_WIDTH-1:0]         count_d;
    logic [WEIGHT_WIDTH-1:0]      weight_q [DATA_LENGTH];
    logic [WEIGHT_WIDTH-1:0]      weight_d [DATA_LENGTH];
    logic signed [ACC_WIDTH-1:0]  acc_q    [DATA_LENGTH];
    logic signed [ACC_WIDTH-1:0]  acc_d    [DATA_LENGTH];

    logic                         w_fire;
    logic                         v_fire;
    logic                         o_fire;
    logic                         last_row;
    logic [WEIGHT_WIDTH-1:0]      weight_sel;
    logic signed [WEIGHT_WIDTH:0] weight_ext;
    logic signed [PROD_WIDTH-1:0] prod [DATA_LENGTH];

    // Handshakes are qualified by state, so stray valids in other states are ignored.
    assign w_fire   = w_valid   && (state_q == S_IDLE);
    assign v_fire   = v_valid   && (state_q == S_ACCUM);
    assign o_fire   = out_ready && (state_q == S_OUT);
    assign last_row = (count_q == LAST_IDX);

    // The weight for the current V row; zero-extended so the product is signed.
    assign weight_sel = weight_q[count_q];
    assign weight_ext = {1'b0, weight_sel};

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (w_fire)             state_d = S_ACCUM;
            S_ACCUM: if (v_fire && last_row) state_d = S_OUT;
            S_OUT:   if (o_fire)             state_d = S_IDLE;
            default:                         state_d = S_IDLE;
        endcase
    end

    // Output decode: each handshake signal is high in exactly one state.
    always_comb begin
        w_ready   = 1'b0;
        v_ready   = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            S_IDLE:  w_ready   = 1'b1;
            S_ACCUM: v_ready   = 1'b1;
            S_OUT:   out_valid = 1'b1;
            default: ;
        endcase
    end

    // Per-lane signed product of the current weight and the incoming V element.
    generate
        for (genvar j = 0; j < DATA_LENGTH; j++) begin : g_prod
            logic signed [DATA_WIDTH-1:0] v_elem;
            assign v_elem  = v_in[j*DATA_WIDTH +: DATA_WIDTH];
            assign prod[j] = weight_ext * v_elem;
        end
    endgenerate

    // Datapath next-state: latch weights and clear on a new row, accumulate per V beat.
    always_comb begin
        count_d = count_q;
        for (int i = 0; i < DATA_LENGTH; i++) begin
            weight_d[i] = weight_q[i];
            acc_d[i]    = acc_q[i];
        end
        if (w_fire) begin
            count_d = '0;
            for (int i = 0; i < DATA_LENGTH; i++) begin
                weight_d[i] = w_in[i*WEIGHT_WIDTH +: WEIGHT_WIDTH];
                acc_d[i]    = '0;
            end
        end else if (v_fire) begin
            count_d = last_row ? '0 : count_q + CNT_WIDTH'(1);
            for (int j = 0; j < DATA_LENGTH; j++) begin
                acc_d[j] = acc_q[j] + ACC_WIDTH'(prod[j]);
            end
        end
    end

    // Datapath registers; reset discards any partially accumulated row.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            for (int i = 0; i < DATA_LENGTH; i++) begin
                weight_q[i] <= '0;
                acc_q[i]    <= '0;
            end
        end else begin
            count_q <= count_d;
            for (int i = 0; i < DATA_LENGTH; i++) begin
                weight_q[i] <= weight_d[i];
                acc_q[i]    <= acc_d[i];
            end
        end
    end

    // Output quantization from Q16.16 accumulators back to the V format.
    generate
        for (genvar j = 0; j < DATA_LENGTH; j++) begin : g_out
`ifdef ATTN_VALUE_SATURATE_EN
            localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
                {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
            localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
                {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};
            logic signed [ACC_WIDTH-1:0] shifted;
            logic        [DATA_WIDTH-1:0] elem;
            assign shifted = acc_q[j] >>> FRAC_BITS;
            // Clamp the floor-shifted value into the signed output range.
            always_comb begin
                elem = shifted[DATA_WIDTH-1:0];
                if (shifted > SAT_MAX) begin
                    elem = SAT_MAX[DATA_WIDTH-1:0];
                end else if (shifted < SAT_MIN) begin
                    elem = SAT_MIN[DATA_WIDTH-1:0];
                end
            end
            assign out[j*DATA_WIDTH +: DATA_WIDTH] = elem;
`else
            // Plain bit select: floor shift with two's-complement wrap.
            assign out[j*DATA_WIDTH +: DATA_WIDTH] = acc_q[j][DATA_WIDTH+FRAC_BITS-1:FRAC_BITS];
`endif
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_attn_value_accumulator.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_attn_value_accumulator
// Description : Self-checking bench for attn_value_accumulator. A reference
//               model computes each output row from plain integer arithmetic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_attn_value_accumulator;

    localparam int N  = 4;
    localparam int WW = 16;
    localparam int DW = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic [WW*N-1:0]   w_in;
    logic              w_valid;
    logic              w_ready;
    logic [DW*N-1:0]   v_in;
    logic              v_valid;
    logic              v_ready;
    logic [DW*N-1:0]   out;
    logic              out_valid;
    logic              out_ready;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    logic [WW-1:0]   tw [N];
    logic [DW-1:0]   tv [N][N];
    logic [DW*N-1:0] exp_out;

    attn_value_accumulator #(
        .WEIGHT_WIDTH (WW),
        .DATA_WIDTH   (DW),
        .DATA_LENGTH  (N)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .w_in      (w_in),
        .w_valid   (w_valid),
        .w_ready   (w_ready),
        .v_in      (v_in),
        .v_valid   (v_valid),
        .v_ready   (v_ready),
        .out       (out),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, fails);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: o[j] = floor(sum_i w[i]*v[i][j] / 256), then wrap or clamp to 16 bits.
    task automatic model();
        for (int j = 0; j < N; j++) begin
            longint s;
            s = 0;
            for (int i = 0; i < N; i++) begin
                s += longint'(tw[i]) * longint'($signed(tv[i][j]));
            end
            s = s >>> 8;
`ifdef ATTN_VALUE_SATURATE_EN
            if (s > 32767)  s = 32767;
            if (s < -32768) s = -32768;
`endif
            exp_out[j*DW +: DW] = s[DW-1:0];
        end
    endtask

    task automatic fill_const(input logic [WW-1:0] wv, input logic [DW-1:0] vv);
        for (int i = 0; i < N; i++) begin
            tw[i] = wv;
            for (int j = 0; j < N; j++) tv[i][j] = vv;
        end
    endtask

    task automatic fill_rand();
        for (int i = 0; i < N; i++) begin
            tw[i] = WW'($urandom_range(0, 16'hFFFF));
            for (int j = 0; j < N; j++) tv[i][j] = DW'($urandom_range(0, 16'hFFFF));
        end
    endtask

    // Push one weight row and N V rows, then drain the output with optional backpressure.
    task automatic run_row(input string tag, input int gaps, input int bp);
        int k;
        int t_w;
        model();
        for (int i = 0; i < N; i++) w_in[i*WW +: WW] = tw[i];
        w_valid = 1'b1;
        k = 0;
        while (!w_ready && k < 20) begin tick(); k++; end
        chk({tag, " w_ready"}, 64'(w_ready), 64'd1);
        tick();
        t_w = cyc;
        w_valid = 1'b0;
        w_in = '0;
        for (int r = 0; r < N; r++) begin
            if (gaps > 0) begin
                v_valid = 1'b0;
                repeat ($urandom_range(1, gaps)) tick();
            end
            chk({tag, " out_valid early"}, 64'(out_valid), 64'd0);
            for (int j = 0; j < N; j++) v_in[j*DW +: DW] = tv[r][j];
            v_valid = 1'b1;
            k = 0;
            while (!v_ready && k < 20) begin tick(); k++; end
            chk({tag, " v_ready"}, 64'(v_ready), 64'd1);
            tick();
        end
        v_valid = 1'b0;
        chk({tag, " out_valid"}, 64'(out_valid), 64'd1);
        chk({tag, " out"}, 64'(out), 64'(exp_out));
        if (gaps == 0) chk({tag, " latency"}, 64'(cyc - t_w), 64'(N));
        // Stray valids while the output is stalled must be ignored.
        out_ready = 1'b0;
        w_valid   = 1'b1;
        v_valid   = 1'b1;
        w_in      = {$urandom, $urandom};
        v_in      = {$urandom, $urandom};
        for (int b = 0; b < bp; b++) begin
            tick();
            chk({tag, " bp out"}, 64'(out), 64'(exp_out));
            chk({tag, " bp ready"}, {62'd0, w_ready, v_ready}, 64'd0);
            chk({tag, " bp out_valid"}, 64'(out_valid), 64'd1);
        end
        w_valid   = 1'b0;
        v_valid   = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, " post out_valid"}, 64'(out_valid), 64'd0);
        chk({tag, " post w_ready"}, 64'(w_ready), 64'd1);
    endtask

    initial begin
        rst       = 1'b1;
        w_in      = '0;
        w_valid   = 1'b0;
        v_in      = '0;
        v_valid   = 1'b0;
        out_ready = 1'b0;
        repeat (2) tick();
        chk("reset out", 64'(out), 64'd0);
        chk("reset w_ready", 64'(w_ready), 64'd1);
        chk("reset v_ready", 64'(v_ready), 64'd0);
        chk("reset out_valid", 64'(out_valid), 64'd0);
        rst = 1'b0;
        tick();

        // Unit weights and unit values: each output is 4.0.
        fill_const(16'h0100, 16'h0100);
        run_row("all_one", 0, 0);
        chk("all_one value", 64'(exp_out), 64'h0400_0400_0400_0400);

        // Only w0 is non-zero: output equals V row 0.
        fill_const(16'h0000, 16'h1234);
        tw[0] = 16'h0100;
        tv[0][0] = 16'h0100; tv[0][1] = 16'h0200; tv[0][2] = 16'h0300; tv[0][3] = 16'h0400;
        run_row("select_w0", 0, 0);

        // Negative values.
        fill_const(16'h0100, 16'hFF00);
        run_row("neg_one", 0, 0);
        chk("neg_one value", 64'(exp_out), 64'hFC00_FC00_FC00_FC00);

        // Output overflow: 4*255*127 far exceeds the Q8.8 range.
        fill_const(16'hFF00, 16'h7F00);
        run_row("overflow", 0, 0);
`ifdef ATTN_VALUE_SATURATE_EN
        chk("overflow value", 64'(exp_out), 64'h7FFF_7FFF_7FFF_7FFF);
`else
        chk("overflow value", 64'(exp_out), 64'h0400_0400_0400_0400);
`endif

        // Held backpressure with stray valids.
        fill_rand();
        run_row("backpressure", 0, 5);

        // Gaps in v_valid give the same result as back-to-back rows.
        fill_const(16'h0100, 16'h0100);
        run_row("gaps", 3, 0);

        // Reset after two V rows aborts the row.
        fill_rand();
        for (int i = 0; i < N; i++) w_in[i*WW +: WW] = tw[i];
        w_valid = 1'b1;
        tick();
        w_valid = 1'b0;
        v_in    = {$urandom, $urandom};
        v_valid = 1'b1;
        repeat (2) tick();
        v_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("midreset out_valid", 64'(out_valid), 64'd0);
        chk("midreset w_ready", 64'(w_ready), 64'd1);
        chk("midreset v_ready", 64'(v_ready), 64'd0);
        chk("midreset out", 64'(out), 64'd0);
        tick();
        rst = 1'b0;
        tick();
        fill_const(16'h0100, 16'h0100);
        run_row("after_reset", 0, 0);

        // Randomized rows with random gaps and backpressure.
        for (int t = 0; t < 10; t++) begin
            fill_rand();
            run_row("random", int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/attn_value_accumulator.md
Name: attn_value_accumulator

Overview:
- Downstream consumer of the softmax stage. Computes one attention output row o[j] = sum_i p[i]*V[i][j].
- Takes one packed softmax weight row p, then streams DATA_LENGTH rows of V, one per accepted beat, and multiply-accumulates them.
- Presents the quantized output row through a valid/ready handshake to the next attention stage.

Parameters:
- WEIGHT_WIDTH, 16, softmax weight width; unsigned Q8.8 (integer width = WEIGHT_WIDTH/2).
- DATA_WIDTH, 16, V element and output element width; signed two's-complement Q8.8.
- DATA_LENGTH, 4, row length; number of weights, number of V rows, and elements per V row and output row.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- w_in  in  WEIGHT_WIDTH*DATA_LENGTH  packed weight row; element i at bits [W*(i+1)-1 : W*i].
- w_valid  in  1  weight row valid.
- w_ready  out  1  weight row accepted when w_valid && w_ready.
- v_in  in  DATA_WIDTH*DATA_LENGTH  packed V row; element j at bits [D*(j+1)-1 : D*j].
- v_valid  in  1  V row valid.
- v_ready  out  1  V row accepted when v_valid && v_ready.
- out  out  DATA_WIDTH*DATA_LENGTH  packed output row, same packing as v_in.
- out_valid  out  1  output row valid.
- out_ready  in  1  downstream accepts the row when out_valid && out_ready.

Behaviour:
- Reset (async, immediate): state=IDLE, count=0, all accumulators=0, weight register=0, w_ready=1, v_ready=0, out_valid=0, out=0. Reset mid-operation discards the partial row.
- States: IDLE, ACCUM, OUT. w_ready=1 only in IDLE; v_ready=1 only in ACCUM; out_valid=1 only in OUT.
- IDLE: on a weight handshake, latch w_in, clear all accumulators, set count=0, go to ACCUM.
- ACCUM: on each V handshake, for every j: acc[j] += w[count] * v_in[j]; then count++.
  - Weight operand is zero-extended to signed; the product is signed.
  - Accumulators use localparam ACC_WIDTH = WEIGHT_WIDTH + DATA_WIDTH + 1 + $clog2(DATA_LENGTH). No overflow is possible inside the accumulator.
  - On the handshake with count == DATA_LENGTH-1, go to OUT and reset count to 0.
  - No V handshake in a cycle leaves state and accumulators unchanged. Gaps in v_valid are legal.
- OUT:
  - out is derived combinationally from the registered accumulators, so it is stable while out_valid is held.
  - Accumulators hold Q16.16; out[j] = acc[j] >> 8, i.e. truncation toward -inf.
  - On the out handshake, go to IDLE. The next weight row can be accepted no earlier than the following cycle.
- Latency: weight accepted at edge T, back-to-back V rows at edges T+1..T+DATA_LENGTH, out_valid high after edge T+DATA_LENGTH (first cycle it can be sampled is T+DATA_LENGTH+1).
- Backpressure: out_ready low holds OUT indefinitely; w_ready and v_ready stay 0; out does not change.
- v_valid in IDLE/OUT and w_valid in ACCUM/OUT are ignored (no handshake).
- DATA_LENGTH=1 is legal: a single V row completes the row.

Optional Feature:
- Macro: ATTN_VALUE_SATURATE_EN.
- Defined: each shifted accumulator is clamped to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1] before driving out (0x8000..0x7FFF at default width).
- Undefined: out[j] = bits [DATA_WIDTH+7 : 8] of acc[j], i.e. two's-complement wrap with no clamp logic.

Test Plan:
- All weights 0x0100, all V elements 0x0100, 4 back-to-back rows -> out = {0x0400 x4}; out_valid first seen at cycle T+5.
- w = {0,0,0,0x0100} (w0=1.0), V row0 = {0x0400,0x0300,0x0200,0x0100}, rows1-3 = 0x1234 -> out = {0x0400,0x0300,0x0200,0x0100}.
- All weights 0x0100, all V elements 0xFF00 (-1.0) -> out = {0xFC00 x4}.
- Overflow: weights 0xFF00 (255.0), V 0x7F00 (127.0) -> out = 0x7FFF per element with ATTN_VALUE_SATURATE_EN; 0x0400 per element without.
- Backpressure: hold out_ready=0 for 5 cycles in OUT while w_valid=1 and v_valid=1 -> out stable, w_ready=0, v_ready=0; single-cycle handshake then IDLE; gaps in v_valid during ACCUM give the same result as back-to-back rows.
- Reset mid-ACCUM after 2 V rows -> out_valid=0, w_ready=1 immediately; the next full row computes correctly with no residue from the aborted row.
